mem_req_ctrl: RTL and testbench
===============================

Name: mem_req_ctrl

Overview:
- Memory request controller that sits directly upstream of the data memory model. It turns pipeline load/store requests (valid/ready) into the memory's level-based re/we + finished handshake.
- Stores are posted into a small in-order write buffer and drained independently on the write channel.
- Loads use the read channel. A load whose address matches a buffered store is forwarded from the buffer.

Parameters:
WB_DEPTH, 4, write-buffer entries (power of 2, >=2)
WB_PTR_W, 2, log2(WB_DEPTH)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
req_valid  input  1  pipeline request valid
req_ready  output  1  controller can accept a request this cycle
req_we  input  1  1=store, 0=load
req_addr  input  32  request address
req_wdata  input  32  store data
rsp_valid  output  1  one-cycle pulse: load data valid
rsp_data  output  32  load data
rsp_fwd  output  1  qualifies rsp_valid; 1 = data came from the write buffer
wb_empty  output  1  write buffer empty and no write in flight (fence status)
wb_count  output  WB_PTR_W+1  occupied buffer entries
mem_re  output  1  memory read enable
mem_r_addr  output  32  memory read address
mem_r_finished  input  1  memory read done (idle = 1)
mem_d_out  input  32  memory read data
mem_we  output  1  memory write enable
mem_w_addr  output  32  memory write address
mem_d_in  output  32  memory write data
mem_w_finished  input  1  memory write done (idle = 1)

Behaviour:
- Reset (asynchronous, immediate): all outputs 0 except wb_empty=1. Both FSMs go to IDLE and the buffer is emptied.
- Reset mid-transaction aborts the transaction. No rsp_valid is produced and no buffer entry survives.
- req_ready = (rd_state==RD_IDLE) && mem_r_finished && !wb_full.
  - It is registered-state based and never depends on req_valid or req_we.
  - Handshake occurs when req_valid && req_ready at a rising edge. At most one request per cycle.
- Store accept: the entry {addr, data} is written at the tail and wb_count increments.
  - If a drain pop happens in the same cycle, wb_count is unchanged.
  - A store is complete to the pipeline on acceptance; there is no response.
- Load accept: req_addr is compared against all valid buffer entries, including the head entry currently being written.
  - Hit: the youngest matching entry's data is used. Next cycle go to RD_RESP with rsp_fwd=1, so latency is 1 cycle and mem_re never asserts.
  - Miss: latch the address and go to RD_REQ.
- Read FSM states: RD_IDLE, RD_REQ, RD_WAIT, RD_RESP.
  - RD_REQ: mem_re=1 and mem_r_addr=latched address. Stay until mem_r_finished==0 is sampled, then go to RD_WAIT.
  - RD_WAIT: mem_re stays 1 and the address is held stable. When mem_r_finished==1 is sampled, capture mem_d_out and go to RD_RESP.
  - RD_RESP: rsp_valid=1 for exactly one cycle, mem_re=0. Then return to RD_IDLE.
  - rsp_data holds its value until the next response.
- Write drain FSM states: WR_IDLE, WR_REQ, WR_WAIT, WR_GAP.
  - WR_IDLE: if the buffer is non-empty and mem_w_finished==1, go to WR_REQ.
  - WR_REQ: mem_we=1, mem_w_addr/mem_d_in = head entry. Stay until mem_w_finished==0.
  - WR_WAIT: mem_we stays 1. When mem_w_finished==1, pop the head and go to WR_GAP.
  - WR_GAP: mem_we=0 for one cycle, then return to WR_IDLE. This guarantees a we edge even for back-to-back writes to the same address.
- mem_re and mem_we may be high simultaneously, since the channels are independent. Ordering is preserved by forwarding plus in-order drain.
- After reset, a channel does not issue until its finished input is sampled 1. This discards any completion left over from an aborted transaction.
- Full buffer: req_ready=0 (loads included) until one pop. Empty buffer: the drain FSM stays in WR_IDLE.
- wb_empty = (wb_count==0) && wr_state==WR_IDLE.
- Pointers wrap modulo WB_DEPTH. wb_count ranges 0..WB_DEPTH.

Test Plan:
- Reset, then load 0x100; memory returns 0xDEADBEEF after 15 ns (10 ns clk) -> mem_re=1 with mem_r_addr=0x100 held until finished rises; a single rsp_valid pulse with rsp_data=0xDEADBEEF, rsp_fwd=0; mem_re=0 during RD_RESP.
- Store 0x200/0x12345678, then immediately load 0x200 -> rsp_valid 1 cycle after load accept, rsp_data=0x12345678, rsp_fwd=1, mem_re never asserted.
- Stores to 0x300 (0xA) then 0x300 (0xB), then load 0x300 -> rsp_data=0xB. Memory sees two writes in order (0xA then 0xB), with mem_we low for at least 1 cycle between them.
- Five back-to-back stores with mem_w_finished held 0 -> req_ready drops after the 4th, wb_count=4. Release -> first pop lowers wb_count to 3, the 5th store is accepted, and all five drain in order. wb_empty=1 at the end.
- Load miss overlapping an active drain -> mem_re and mem_we both high; the load response is correct and the drain is unaffected.
- Assert reset during RD_WAIT with mem_r_finished=0 -> all outputs 0 immediately, no rsp_valid. req_ready stays 0 until mem_r_finished=1. The next load completes normally.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - load/store request controller with posted write buffer and store-to-load forwarding
module mem_req_ctrl #(
  parameter int WB_DEPTH = 4,
  parameter int WB_PTR_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_data,
  output logic                rsp_fwd,
  output logic                wb_empty,
  output logic [WB_PTR_W:0]   wb_count,
  output logic                mem_re,
  output logic [31:0]         mem_r_addr,
  input  logic                mem_r_finished,
  input  logic [31:0]         mem_d_out,
  output logic                mem_we,
  output logic [31:0]         mem_w_addr,
  output logic [31:0]         mem_d_in,
  input  logic                mem_w_finished
);

  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_WAIT, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_WAIT, WR_GAP} wr_state_t;

  localparam logic [WB_PTR_W:0]   CNT_FULL = WB_DEPTH[WB_PTR_W:0];
  localparam logic [WB_PTR_W:0]   CNT_ONE  = 1;
  localparam logic [WB_PTR_W-1:0] PTR_ONE  = 1;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic [31:0]         wb_addr [WB_DEPTH];
  logic [31:0]         wb_data [WB_DEPTH];
  logic [WB_PTR_W-1:0] wb_head, wb_tail;
  logic [WB_PTR_W:0]   count_q;
  logic [31:0]         rd_addr, rsp_data_q;
  logic                fwd_q, rd_armed;

  logic        wb_full, accept, push, pop, load_acc, fwd_hit;
  logic [31:0] fwd_data;

  assign wb_full  = (count_q == CNT_FULL);
  // rd_armed holds the read channel off after reset until a clean finished=1 is seen
  assign req_ready = (rd_state == RD_IDLE) && rd_armed && mem_r_finished && !wb_full;
  assign accept   = req_valid && req_ready;
  assign push     = accept && req_we;
  assign load_acc = accept && !req_we;
  assign pop      = (wr_state == WR_WAIT) && mem_w_finished;

  // Scan oldest to youngest so the last match is the youngest store
  always_comb begin
    logic [WB_PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = wb_head + i[WB_PTR_W-1:0];
      if ((i[WB_PTR_W:0] < count_q) && (wb_addr[idx] == req_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[idx];
      end
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (load_acc) rd_next = fwd_hit ? RD_RESP : RD_REQ;
      RD_REQ:  if (!mem_r_finished) rd_next = RD_WAIT;
      RD_WAIT: if (mem_r_finished) rd_next = RD_RESP;
      RD_RESP: rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if ((count_q != '0) && mem_w_finished) wr_next = WR_REQ;
      WR_REQ:  if (!mem_w_finished) wr_next = WR_WAIT;
      WR_WAIT: if (mem_w_finished) wr_next = WR_GAP;
      WR_GAP:  wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  assign mem_re     = (rd_state == RD_REQ) || (rd_state == RD_WAIT);
  assign mem_r_addr = rd_addr;
  assign rsp_valid  = (rd_state == RD_RESP);
  assign rsp_fwd    = rsp_valid && fwd_q;
  assign rsp_data   = rsp_data_q;

  assign mem_we     = (wr_state == WR_REQ) || (wr_state == WR_WAIT);
  assign mem_w_addr = mem_we ? wb_addr[wb_head] : '0;
  assign mem_d_in   = mem_we ? wb_data[wb_head] : '0;

  assign wb_count = count_q;
  assign wb_empty = (count_q == '0) && (wr_state == WR_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state   <= RD_IDLE;
      wr_state   <= WR_IDLE;
      wb_head    <= '0;
      wb_tail    <= '0;
      count_q    <= '0;
      rd_addr    <= '0;
      rsp_data_q <= '0;
      fwd_q      <= 1'b0;
      rd_armed   <= 1'b0;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
      if (mem_r_finished) rd_armed <= 1'b1;
      if (push) wb_tail <= wb_tail + PTR_ONE;
      if (pop)  wb_head <= wb_head + PTR_ONE;
      if (push && !pop)      count_q <= count_q + CNT_ONE;
      else if (pop && !push) count_q <= count_q - CNT_ONE;
      if (load_acc) begin
        if (fwd_hit) begin
          rsp_data_q <= fwd_data;
          fwd_q      <= 1'b1;
        end else begin
          rd_addr <= req_addr;
        end
      end
      if ((rd_state == RD_WAIT) && mem_r_finished) begin
        rsp_data_q <= mem_d_out;
        fwd_q      <= 1'b0;
      end
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[wb_tail] <= req_addr;
      wb_data[wb_tail] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed self-checking bench for mem_req_ctrl
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_fwd, wb_empty, mem_re, mem_we;
  logic [31:0] rsp_data, mem_r_addr, mem_w_addr, mem_d_in;
  logic [2:0]  wb_count;
  logic        mem_r_finished = 1'b1, mem_w_finished = 1'b1;
  logic [31:0] mem_d_out = '0;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [1024];
  logic [31:0] log_a [$];
  logic [31:0] log_d [$];
  int          rd_lat = 0;
  logic        wr_hold = 1'b0;
  int          re_rises = 0, rsp_cnt = 0;

  always #5 clk = ~clk;

  mem_req_ctrl #(.WB_DEPTH(4), .WB_PTR_W(2)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fwd(rsp_fwd),
    .wb_empty(wb_empty), .wb_count(wb_count),
    .mem_re(mem_re), .mem_r_addr(mem_r_addr), .mem_r_finished(mem_r_finished),
    .mem_d_out(mem_d_out),
    .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_d_in(mem_d_in),
    .mem_w_finished(mem_w_finished)
  );

  // Memory model: finished drops on a new enable edge and rises after rd_lat/hold
  logic        r_pend = 1'b0, prev_re = 1'b0;
  int          r_cnt = 0;
  logic [31:0] r_a = '0;
  always @(negedge clk) begin
    if (r_pend) begin
      if (r_cnt > 0) r_cnt--;
      else begin
        mem_d_out      = mem[r_a[11:2]];
        mem_r_finished = 1'b1;
        r_pend         = 1'b0;
      end
    end else if (mem_re && !prev_re) begin
      r_a            = mem_r_addr;
      mem_r_finished = 1'b0;
      r_pend         = 1'b1;
      r_cnt          = rd_lat;
    end
    prev_re = mem_re;
  end

  logic        w_pend = 1'b0, prev_we = 1'b0;
  logic [31:0] w_a = '0, w_d = '0;
  always @(negedge clk) begin
    if (w_pend) begin
      if (!wr_hold) begin
        mem[w_a[11:2]] = w_d;
        log_a.push_back(w_a);
        log_d.push_back(w_d);
        mem_w_finished = 1'b1;
        w_pend         = 1'b0;
      end
    end else if (mem_we && !prev_we) begin
      w_a            = mem_w_addr;
      w_d            = mem_d_in;
      mem_w_finished = 1'b0;
      w_pend         = 1'b1;
    end
    prev_we = mem_we;
  end

  logic mon_prev_re = 1'b0;
  always @(negedge clk) begin
    if (mem_re && !mon_prev_re) re_rises++;
    mon_prev_re = mem_re;
    if (rsp_valid) rsp_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk); #2;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    check("accept_in_time", 32'(n < 200), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input logic [31:0] a, output int n, output int addr_bad);
    n = 0;
    addr_bad = 0;
    while (!rsp_valid && n < 100) begin
      if (mem_re && (mem_r_addr !== a)) addr_bad++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (!wb_empty && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(wb_empty), 32'd1);
  endtask

  initial begin
    int n, ab, base, base_re, base_rsp, rdy_bad;
    mem[64] = 32'hDEADBEEF;
    mem[65] = 32'hCAFEF00D;

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_fwd", 32'(rsp_fwd), 32'd0);
    check("rst_wb_empty", 32'(wb_empty), 32'd1);
    check("rst_wb_count", 32'(wb_count), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_r_addr", mem_r_addr, 32'd0);
    check("rst_mem_w_addr", mem_w_addr, 32'd0);
    check("rst_mem_d_in", mem_d_in, 32'd0);
    @(negedge clk); #2 rst = 1'b0;

    // Load miss from memory
    send(1'b0, 32'h100, 32'h0);
    check("t1_mem_re", 32'(mem_re), 32'd1);
    check("t1_mem_r_addr", mem_r_addr, 32'h100);
    wait_rsp(32'h100, n, ab);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_data", rsp_data, 32'hDEADBEEF);
    check("t1_rsp_fwd", 32'(rsp_fwd), 32'd0);
    check("t1_re_in_resp", 32'(mem_re), 32'd0);
    check("t1_addr_stable", 32'(ab), 32'd0);
    @(posedge clk); #1;
    check("t1_single_pulse", 32'(rsp_valid), 32'd0);
    check("t1_rsp_cnt", 32'(rsp_cnt), 32'd1);
    check("t1_rsp_hold", rsp_data, 32'hDEADBEEF);

    // Store then immediate load to same address: forwarded
    base_re = re_rises;
    send(1'b1, 32'h200, 32'h12345678);
    send(1'b0, 32'h200, 32'h0);
    wait_rsp(32'h200, n, ab);
    check("t2_latency", 32'(n), 32'd0);
    check("t2_rsp_data", rsp_data, 32'h12345678);
    check("t2_rsp_fwd", 32'(rsp_fwd), 32'd1);
    check("t2_no_mem_re", 32'(re_rises), 32'(base_re));
    wait_empty("t2_empty");

    // Two stores to one address: youngest forwarded, both written in order
    base = log_a.size();
    send(1'b1, 32'h300, 32'hA);
    send(1'b1, 32'h300, 32'hB);
    send(1'b0, 32'h300, 32'h0);
    wait_rsp(32'h300, n, ab);
    check("t3_rsp_data", rsp_data, 32'hB);
    check("t3_rsp_fwd", 32'(rsp_fwd), 32'd1);
    wait_empty("t3_empty");
    check("t3_nwrites", 32'(log_a.size() - base), 32'd2);
    if (log_a.size() >= base + 2) begin
      check("t3_w0_addr", log_a[base], 32'h300);
      check("t3_w0_data", log_d[base], 32'hA);
      check("t3_w1_addr", log_a[base + 1], 32'h300);
      check("t3_w1_data", log_d[base + 1], 32'hB);
    end

    // Fill the buffer with the drain stalled
    base = log_a.size();
    wr_hold = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b1, 32'h400 + 32'(4 * i), 32'h40 + 32'(i));
    check("t4_count_full", 32'(wb_count), 32'd4);
    @(negedge clk); #2;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h410; req_wdata = 32'h44;
    check("t4_ready_low", 32'(req_ready), 32'd0);
    repeat (3) begin @(negedge clk); #2; end
    check("t4_still_full", 32'(wb_count), 32'd4);
    check("t4_still_blocked", 32'(req_ready), 32'd0);
    wr_hold = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    check("t4_ready_after_pop", 32'(req_ready), 32'd1);
    check("t4_count_after_pop", 32'(wb_count), 32'd3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("t4_count_after_5th", 32'(wb_count), 32'd4);
    wait_empty("t4_empty");
    check("t4_nwrites", 32'(log_a.size() - base), 32'd5);
    if (log_a.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) begin
        check("t4_w_addr", log_a[base + i], 32'h400 + 32'(4 * i));
        check("t4_w_data", log_d[base + i], 32'h40 + 32'(i));
      end
    end

    // Load miss overlapping a stalled drain
    base = log_a.size();
    wr_hold = 1'b1;
    send(1'b1, 32'h500, 32'h55);
    send(1'b0, 32'h100, 32'h0);
    check("t5_re_we_both", 32'({mem_re, mem_we}), 32'd3);
    wait_rsp(32'h100, n, ab);
    check("t5_rsp_data", rsp_data, 32'hDEADBEEF);
    check("t5_rsp_fwd", 32'(rsp_fwd), 32'd0);
    check("t5_drain_pending", 32'(wb_count), 32'd1);
    wr_hold = 1'b0;
    wait_empty("t5_empty");
    check("t5_nwrites", 32'(log_a.size() - base), 32'd1);
    if (log_a.size() >= base + 1) check("t5_w_data", log_d[base], 32'h55);

    // Reset during RD_WAIT
    rd_lat = 6;
    base_rsp = rsp_cnt;
    send(1'b0, 32'h100, 32'h0);
    @(posedge clk); #1;
    check("t6_in_wait", 32'({mem_re, mem_r_finished}), 32'd2);
    rst = 1'b1;
    #1;
    check("t6_rst_mem_re", 32'(mem_re), 32'd0);
    check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_rst_req_ready", 32'(req_ready), 32'd0);
    check("t6_rst_wb_empty", 32'(wb_empty), 32'd1);
    check("t6_rst_mem_r_addr", mem_r_addr, 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    rdy_bad = 0;
    n = 0;
    while (!mem_r_finished && n < 50) begin
      if (req_ready) rdy_bad++;
      @(posedge clk); #1;
      n++;
    end
    check("t6_ready_held_low", 32'(rdy_bad), 32'd0);
    check("t6_no_rsp", 32'(rsp_cnt), 32'(base_rsp));
    rd_lat = 0;
    send(1'b0, 32'h104, 32'h0);
    wait_rsp(32'h104, n, ab);
    check("t6_next_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t6_next_rsp_data", rsp_data, 32'hCAFEF00D);
    check("t6_next_rsp_fwd", 32'(rsp_fwd), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
